slc3_control_fsm: RTL and testbench

Instruction sequencing and decode controller for the SLC-3 datapath.
- Steps the fetch / decode / execute micro-sequence.
- Drives every register-load, bus-gate and mux-select control and the memory strobes.
- Handles the Run/Continue front-panel handshake.
- Sits between the top-level button inputs and the datapath inside the SLC-3 top, so the processor runs from the same Clk/Reset/Run/Continue pins the bench drives.

---
 rtl/slc3_control_fsm_if.sv | 35 +++
 rtl/slc3_control_fsm.sv | 157 +++++++++++++++
 tb/tb_slc3_control_fsm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/slc3_control_fsm_if.sv
// Control bundle between the SLC-3 sequencer and its datapath/front panel.
// master = the controller, slave = datapath side.
interface slc3_control_fsm_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_OE, Mem_WE;
    logic [4:0] State;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
               Mem_OE, Mem_WE, State
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
               Mem_OE, Mem_WE, State
    );
endinterface

// File: rtl/slc3_control_fsm.sv
// SLC-3 sequencer: fetch/decode/execute micro-steps, datapath controls,
// memory strobes and the Run/Continue front-panel handshake. Moore, registered outputs.
module slc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input logic                Clk,
    input logic                Reset,
    slc3_control_fsm_if.master bus
);
    localparam int unsigned CW = 3;

    typedef enum logic [4:0] {
        HALTED = 5'd0, FETCH1, FETCH2, FETCH3, DECODE,
        ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR1, JSR2,
        LDR1, LDR2, LDR3, STR1, STR2, STR3,
        PAUSE1, PAUSE2, PAUSE3
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe, mem_we;
    } ctl_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    ctl_t          ctl;

    function automatic logic last_beat(input logic [CW-1:0] w);
        return w == CW'(MEM_WAIT - 1);
    endfunction

    function automatic logic mem_state(input state_t s);
        return (s == FETCH2) || (s == LDR2) || (s == STR3);
    endfunction

    // Counter runs only inside a memory access and clears as the access ends.
    function automatic logic [CW-1:0] next_wait(input state_t s, input logic [CW-1:0] w);
        if (!mem_state(s) || last_beat(w)) return '0;
        return w + CW'(1);
    endfunction

    function automatic state_t next_state(input state_t s, input logic [CW-1:0] w,
                                          input logic run, input logic cont,
                                          input logic [3:0] op, input logic ben);
        case (s)
            HALTED:   return run ? HALTED : FETCH1;
            FETCH1:   return FETCH2;
            FETCH2:   return last_beat(w) ? FETCH3 : FETCH2;
            FETCH3:   return DECODE;
            DECODE: begin
                case (op)
                    4'b0001: return ADD;
                    4'b0101: return AND;
                    4'b1001: return NOT;
                    4'b0000: return BR;
                    4'b1100: return JMP;
                    4'b0100: return JSR1;
                    4'b0110: return LDR1;
                    4'b0111: return STR1;
                    4'b1101: return PAUSE1;
                    default: return FETCH1;
                endcase
            end
            BR:       return ben ? BR_TAKEN : FETCH1;
            JSR1:     return JSR2;
            LDR1:     return LDR2;
            LDR2:     return last_beat(w) ? LDR3 : LDR2;
            STR1:     return STR2;
            STR2:     return STR3;
            STR3:     return last_beat(w) ? FETCH1 : STR3;
            PAUSE1:   return PAUSE2;
            PAUSE2:   return cont ? PAUSE2 : PAUSE3;
            PAUSE3:   return cont ? FETCH1 : PAUSE3;
            default:  return FETCH1;
        endcase
    endfunction

    function automatic ctl_t decode(input state_t s, input logic [CW-1:0] w,
                                    input logic ir5, input logic ir11);
        ctl_t c;
        c = '0;
        case (s)
            FETCH1:   begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
            FETCH2, LDR2: begin c.mem_oe = 1'b1; c.ld_mdr = last_beat(w); end
            FETCH3:   begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            DECODE:   c.ld_ben = 1'b1;
            ADD, AND: begin
                c.sr2mux   = ir5;
                c.aluk     = (s == AND) ? 2'b01 : 2'b00;
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            NOT:      begin c.aluk = 2'b10; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            BR_TAKEN: begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
            JMP:      begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.pcmux = 2'b01; c.ld_pc = 1'b1; end
            JSR1:     begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
            JSR2: begin
                c.ld_pc = 1'b1;
                if (ir11) begin
                    c.pcmux = 2'b10; c.addr2mux = 2'b11;
                end else begin
                    c.pcmux = 2'b01; c.aluk = 2'b11; c.gate_alu = 1'b1;
                end
            end
            LDR1, STR1: begin
                c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            LDR3:     begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            STR2:     begin c.sr1mux = 1'b1; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
            STR3:     c.mem_we = 1'b1;
            PAUSE1:   c.ld_led = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
            ctl      <= '0;
        end else begin
            state    <= next_state(state, wait_cnt, bus.Run, bus.Continue, bus.Opcode, bus.BEN);
            wait_cnt <= next_wait(state, wait_cnt);
            ctl      <= decode(next_state(state, wait_cnt, bus.Run, bus.Continue, bus.Opcode, bus.BEN),
                               next_wait(state, wait_cnt), bus.IR_5, bus.IR_11);
        end
    end

    assign bus.LD_MAR     = ctl.ld_mar;
    assign bus.LD_MDR     = ctl.ld_mdr;
    assign bus.LD_IR      = ctl.ld_ir;
    assign bus.LD_BEN     = ctl.ld_ben;
    assign bus.LD_CC      = ctl.ld_cc;
    assign bus.LD_REG     = ctl.ld_reg;
    assign bus.LD_PC      = ctl.ld_pc;
    assign bus.LD_LED     = ctl.ld_led;
    assign bus.GatePC     = ctl.gate_pc;
    assign bus.GateMDR    = ctl.gate_mdr;
    assign bus.GateALU    = ctl.gate_alu;
    assign bus.GateMARMUX = ctl.gate_marmux;
    assign bus.PCMUX      = ctl.pcmux;
    assign bus.DRMUX      = ctl.drmux;
    assign bus.SR1MUX     = ctl.sr1mux;
    assign bus.SR2MUX     = ctl.sr2mux;
    assign bus.ADDR1MUX   = ctl.addr1mux;
    assign bus.ADDR2MUX   = ctl.addr2mux;
    assign bus.ALUK       = ctl.aluk;
    assign bus.Mem_OE     = ctl.mem_oe;
    assign bus.Mem_WE     = ctl.mem_we;
    assign bus.State      = state;
endmodule

// File: tb/tb_slc3_control_fsm.sv
// Scoreboard bench for slc3_control_fsm: a per-instruction micro-step model
// queues the expected control word for each cycle; a monitor pops and compares.
module tb_slc3_control_fsm;
    localparam int MW = 2;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe, mem_we;
    } ctl_t;

    typedef struct { ctl_t c; bit halted; } exp_t;
    typedef struct { logic [3:0] opcode; bit ir5, ir11, ben, early; int p2, p3; } instr_t;

    logic Clk = 1'b0;
    logic Reset;
    slc3_control_fsm_if bus();

    slc3_control_fsm #(.MEM_WAIT(MW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [4:0] halted_state = '0;

    function automatic ctl_t observe();
        ctl_t o;
        o.ld_mar = bus.LD_MAR;   o.ld_mdr = bus.LD_MDR;   o.ld_ir = bus.LD_IR;
        o.ld_ben = bus.LD_BEN;   o.ld_cc = bus.LD_CC;     o.ld_reg = bus.LD_REG;
        o.ld_pc = bus.LD_PC;     o.ld_led = bus.LD_LED;
        o.gate_pc = bus.GatePC;  o.gate_mdr = bus.GateMDR;
        o.gate_alu = bus.GateALU; o.gate_marmux = bus.GateMARMUX;
        o.pcmux = bus.PCMUX;     o.drmux = bus.DRMUX;     o.sr1mux = bus.SR1MUX;
        o.sr2mux = bus.SR2MUX;   o.addr1mux = bus.ADDR1MUX; o.addr2mux = bus.ADDR2MUX;
        o.aluk = bus.ALUK;       o.mem_oe = bus.Mem_OE;   o.mem_we = bus.Mem_WE;
        return o;
    endfunction

    task automatic check(input string name, input bit ok, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic push_e(input ctl_t c, input bit h);
        exp_t e;
        e.c = c;
        e.halted = h;
        exp_q.push_back(e);
    endtask

    // Expected control words, one per cycle, for one whole instruction.
    task automatic model_instr(input instr_t in, output int len);
        ctl_t c;
        int   n0;
        n0 = exp_q.size();
        c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push_e(c, 0);
        for (int i = 0; i < MW; i++) begin
            c = '0; c.mem_oe = 1; c.ld_mdr = (i == MW - 1); push_e(c, 0);
        end
        c = '0; c.gate_mdr = 1; c.ld_ir = 1; push_e(c, 0);
        c = '0; c.ld_ben = 1; push_e(c, 0);
        case (in.opcode)
            4'b0001, 4'b0101: begin
                c = '0; c.sr2mux = in.ir5; c.aluk = (in.opcode == 4'b0101) ? 2'b01 : 2'b00;
                c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; push_e(c, 0);
            end
            4'b1001: begin
                c = '0; c.aluk = 2'b10; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; push_e(c, 0);
            end
            4'b0000: begin
                push_e('0, 0);
                if (in.ben) begin
                    c = '0; c.pcmux = 2'b10; c.addr2mux = 2'b10; c.ld_pc = 1; push_e(c, 0);
                end
            end
            4'b1100: begin
                c = '0; c.aluk = 2'b11; c.gate_alu = 1; c.pcmux = 2'b01; c.ld_pc = 1; push_e(c, 0);
            end
            4'b0100: begin
                c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; push_e(c, 0);
                c = '0; c.ld_pc = 1;
                if (in.ir11) begin c.pcmux = 2'b10; c.addr2mux = 2'b11; end
                else begin c.pcmux = 2'b01; c.aluk = 2'b11; c.gate_alu = 1; end
                push_e(c, 0);
            end
            4'b0110, 4'b0111: begin
                c = '0; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; push_e(c, 0);
                if (in.opcode == 4'b0110) begin
                    for (int i = 0; i < MW; i++) begin
                        c = '0; c.mem_oe = 1; c.ld_mdr = (i == MW - 1); push_e(c, 0);
                    end
                    c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push_e(c, 0);
                end else begin
                    c = '0; c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; push_e(c, 0);
                    for (int i = 0; i < MW; i++) begin
                        c = '0; c.mem_we = 1; push_e(c, 0);
                    end
                end
            end
            4'b1101: begin
                c = '0; c.ld_led = 1; push_e(c, 0);
                for (int i = 0; i < in.p2 + in.p3; i++) push_e('0, 0);
            end
            default: ;
        endcase
        len = exp_q.size() - n0;
    endtask

    function automatic instr_t mk(input logic [3:0] op, input bit ir5, input bit ir11,
                                  input bit ben, input bit early, input int p2, input int p3);
        instr_t in;
        in.opcode = op; in.ir5 = ir5; in.ir11 = ir11; in.ben = ben;
        in.early = early; in.p2 = early ? 1 : p2; in.p3 = p3;
        return in;
    endfunction

    // Called at the falling edge of the cycle before FETCH1; returns at the last cycle's falling edge.
    task automatic issue(input instr_t in, input int keep);
        int len;
        model_instr(in, len);
        if (keep > 0) begin
            while (len > keep) begin void'(exp_q.pop_back()); len--; end
        end
        for (int c = 0; c < len; c++) begin
            @(negedge Clk);
            if (c == 0) begin
                bus.Opcode = in.opcode; bus.IR_5 = in.ir5; bus.IR_11 = in.ir11; bus.BEN = in.ben;
                bus.Run = 1'($urandom);
                bus.Continue = (in.opcode == 4'b1101) ? 1'b1 : 1'($urandom);
            end
            if (in.opcode == 4'b1101) begin
                if (c == (in.early ? MW + 3 : MW + 3 + in.p2)) bus.Continue = 1'b0;
                if (c == len - 1) bus.Continue = 1'b1;
            end
        end
    endtask

    // Monitor: one scoreboard entry per cycle while the queue holds expectations.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                exp_t e;
                ctl_t o;
                e = exp_q.pop_front();
                o = observe();
                check("ctl", o == e.c, 32'(o), 32'(e.c));
                check("gate_onehot", $countones({o.gate_pc, o.gate_mdr, o.gate_alu, o.gate_marmux}) <= 1,
                      32'({o.gate_pc, o.gate_mdr, o.gate_alu, o.gate_marmux}), 32'h1);
                check("oe_we_excl", !(o.mem_oe && o.mem_we), 32'({o.mem_oe, o.mem_we}), 32'h0);
                if (e.halted)
                    check("state_halted", bus.State == halted_state, 32'(bus.State), 32'(halted_state));
                else
                    check("state_running", bus.State != halted_state, 32'(bus.State), 32'(halted_state));
            end
        end
    end

    initial begin
        instr_t d[$];
        Reset = 1'b1;
        bus.Run = 1'b1; bus.Continue = 1'b1; bus.Opcode = 4'h0;
        bus.IR_5 = 1'b0; bus.IR_11 = 1'b0; bus.BEN = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_ctl", observe() == '0, 32'(observe()), 32'h0);
        halted_state = bus.State;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) push_e('0, 1);
        repeat (3) @(negedge Clk);
        bus.Run = 1'b0;

        d.push_back(mk(4'b0001, 1, 0, 0, 0, 1, 1));   // ADD imm
        d.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1));   // BR not taken
        d.push_back(mk(4'b0000, 0, 0, 1, 0, 1, 1));   // BR taken
        d.push_back(mk(4'b0111, 0, 0, 0, 0, 1, 1));   // STR
        d.push_back(mk(4'b1101, 0, 0, 0, 0, 3, 5));   // PAUSE, press held 5 cycles
        d.push_back(mk(4'b1101, 0, 0, 0, 1, 1, 2));   // PAUSE, Continue low on entry
        d.push_back(mk(4'b0100, 0, 0, 0, 0, 1, 1));   // JSRR
        d.push_back(mk(4'b0100, 0, 1, 0, 0, 1, 1));   // JSR
        d.push_back(mk(4'b0110, 0, 0, 0, 0, 1, 1));   // LDR
        d.push_back(mk(4'b0101, 0, 0, 0, 0, 1, 1));   // AND reg
        d.push_back(mk(4'b1001, 0, 0, 0, 0, 1, 1));   // NOT
        d.push_back(mk(4'b1100, 0, 0, 0, 0, 1, 1));   // JMP
        d.push_back(mk(4'b0011, 0, 0, 0, 0, 1, 1));   // NOP
        d.push_back(mk(4'b1111, 0, 0, 0, 0, 1, 1));   // NOP
        for (int i = 0; i < 40; i++)
            d.push_back(mk(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 2) == 0), $urandom_range(1, 3), $urandom_range(1, 4)));
        foreach (d[i]) issue(d[i], 0);

        // Reset asserted during the first LDR2 read cycle.
        issue(mk(4'b0110, 0, 0, 0, 0, 1, 1), MW + 5);
        check("ldr2_oe_before", bus.Mem_OE == 1'b1, 32'(bus.Mem_OE), 32'h1);
        Reset = 1'b1;
        #1;
        check("rst_oe", bus.Mem_OE == 1'b0, 32'(bus.Mem_OE), 32'h0);
        check("rst_ctl", observe() == '0, 32'(observe()), 32'h0);
        check("rst_state", bus.State == halted_state, 32'(bus.State), 32'(halted_state));
        @(negedge Clk);
        Reset = 1'b0;
        bus.Run = 1'b1;
        for (int i = 0; i < 4; i++) push_e('0, 1);
        repeat (4) @(negedge Clk);

        check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
